// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, frame-cycle state encoding and defaults
package fb_pkg;

    localparam int H_RES        = 800;
    localparam int V_RES        = 600;
    localparam int FB_WORDS     = H_RES * V_RES;
    localparam int BUF1_BASE    = FB_WORDS;
    localparam int DRAIN_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        ARM,
        DRAW,
        DRAIN,
        SWAP_WAIT
    } state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: second pipeline stage, forms base + y*800 + x without a multiplier and flags in-range pixels
module fb_addr_gen import fb_pkg::*; #(
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       x,
    input  logic [10:0]       y,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);

    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] sum;

    assign yw  = ADDR_W'(y);
    assign sum = (yw << 9) + (yw << 8) + (yw << 5) + ADDR_W'(x) + base;

    // register the summed address together with the range decision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            in_range <= 1'b0;
        end else begin
            addr     <= sum;
            in_range <= (x < H_LIM) && (y < V_LIM);
        end
    end

endmodule

// File: rtl/fb_writer.sv
// fb_writer: pixel stream sink writing a double-buffered framebuffer and sequencing rasterizer frames
module fb_writer import fb_pkg::*; #(
    parameter int H_RES        = fb_pkg::H_RES,
    parameter int V_RES        = fb_pkg::V_RES,
    parameter int ADDR_W       = 20,
    parameter int DRAIN_CYCLES = fb_pkg::DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              start,
    input  logic              frame_end,
    input  logic [7:0]        in_data,
    input  logic [10:0]       in_x,
    input  logic [10:0]       in_y,
    input  logic              in_draw,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              vsync,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              front_sel,
    output logic              frame_done,
    output logic [15:0]       clip_count
);
    localparam int                QW        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [QW-1:0]     QUIET_MAX = QW'(DRAIN_CYCLES);
    localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(H_RES * V_RES);

    state_t            state;
    state_t            state_nx;
    logic              swap;
    logic              hs;
    logic              drain_done;
    logic [QW-1:0]     quiet;
    logic [ADDR_W-1:0] back_base;
    logic              s1_v;
    logic              s1_draw;
    logic [10:0]       s1_x;
    logic [10:0]       s1_y;
    logic [7:0]        s1_d;
    logic              s2_v;
    logic              s2_draw;
    logic              s2_in;

    assign in_ready   = (state == DRAW) || (state == DRAIN);
    assign hs         = in_valid && in_ready;
    assign drain_done = (quiet == QUIET_MAX) && !s1_v && !s2_v;
    assign fb_we      = s2_v && s2_draw && s2_in;

    // frame-cycle next state; a swap happens only on vsync seen while already waiting
    always_comb begin
        state_nx = state;
        swap     = 1'b0;
        case (state)
            IDLE:      state_nx = run ? KICK : IDLE;
            KICK:      state_nx = ARM;
            ARM:       state_nx = frame_end ? ARM : DRAW;
            DRAW:      state_nx = frame_end ? DRAIN : DRAW;
            DRAIN:     state_nx = drain_done ? SWAP_WAIT : DRAIN;
            SWAP_WAIT: begin
                swap     = vsync;
                state_nx = vsync ? (run ? KICK : IDLE) : SWAP_WAIT;
            end
            default:   state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // start/frame_done pulses, displayed buffer and back-buffer base latched at kick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            front_sel  <= 1'b0;
            back_base  <= '0;
        end else begin
            start      <= state == KICK;
            frame_done <= swap;
            front_sel  <= front_sel ^ swap;
            back_base  <= (state == KICK) ? (front_sel ? '0 : BASE1) : back_base;
        end
    end

    // quiet-cycle counter: cleared while drawing, restarted by any handshake while draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                quiet <= '0;
        else if (state == DRAW)    quiet <= '0;
        else if (state == DRAIN)   quiet <= in_valid ? '0 : (quiet == QUIET_MAX) ? quiet : quiet + 1'b1;
    end

    // first pipeline stage: capture the accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_draw <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_d    <= '0;
        end else begin
            s1_v    <= hs;
            s1_draw <= in_draw;
            s1_x    <= in_x;
            s1_y    <= in_y;
            s1_d    <= in_data;
        end
    end

    // second pipeline stage control, aligned with the address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v     <= 1'b0;
            s2_draw  <= 1'b0;
            fb_wdata <= '0;
        end else begin
            s2_v     <= s1_v;
            s2_draw  <= s1_draw;
            fb_wdata <= s1_d;
        end
    end

    // saturating count of drawn pixels that fell outside the screen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                  clip_count <= '0;
        else if (s2_v && s2_draw && !s2_in && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
    end

    fb_addr_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (s1_x),
        .y        (s1_y),
        .base     (back_base),
        .addr     (fb_addr),
        .in_range (s2_in)
    );

endmodule
